rx_serial_7o1: RTL
==================

# rx_serial_7O1

Asynchronous serial receiver for the 7O1 frame format: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit. It is the receiving end of the link driven by `tx_serial_7O1`. It deserialises one ASCII character per frame, checks parity, and holds the character for the host data path until acknowledged. It sits beside the trena data path so the board can accept serial commands, for example a "measure" character from the PC.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Minimum legal value is 4.

Ports:
- `clock`  in  1  system clock; the only clock domain.
- `reset`  in  1  asynchronous, active-low reset; 0 resets the whole block immediately.
- `entrada_serial`  in  1  serial line; idles at 1; asynchronous to `clock`.
- `recebe_dado`  in  1  host acknowledge; a 1-cycle pulse clears `tem_dado`.
- `dados_ascii`  out  7  last received character.
- `tem_dado`  out  1  a character is held and not yet acknowledged.
- `pronto`  out  1  1-cycle pulse when a frame completes.
- `erro_paridade`  out  1  parity result of the last completed frame; 1 means bad.
- `erro_framing`  out  1  stop bit of the last completed frame was 0. Only meaningful with `RX_FRAMING_CHECK_EN`.
- `db_estado`  out  4  current FSM state code, for debug.

## Operation
- `entrada_serial` passes through a 2-flop synchroniser; all logic uses the synchronised value `s`. The synchroniser flops reset to 1.
- FSM states and codes:
  - `inicial` 0: waits for `s` = 0, the start edge. Loads the bit counter with `CLKS_PER_BIT/2` (floor) and goes to `start`.
  - `start` 1: when the counter expires, samples `s`. If `s` = 1 it is a false start and the FSM returns to `inicial`. Otherwise it reloads the counter with `CLKS_PER_BIT` and goes to `dados`.
  - `dados` 2: at each counter expiry, shifts `s` into a 7-bit register LSB first and reloads. After the 7th sample it goes to `paridade`.
  - `paridade` 3: at expiry, samples the parity bit, reloads, and goes to `parada`.
  - `parada` 4: at expiry, samples the stop bit and goes to `final`.
  - `final` 5: for one cycle, updates the outputs, pulses `pronto`, and returns to `inicial`.
- Parity: `erro_paridade` = NOT(XOR of the 7 data bits and the parity bit). A correct frame has an odd number of 1s across data and parity.
- In `final`:
  - `dados_ascii` is loaded from the shift register.
  - `erro_paridade` and `erro_framing` are loaded.
  - `tem_dado` is set to 1.
  - A character with a parity error is still delivered and `tem_dado` is still set.
- `tem_dado` clears on `recebe_dado` = 1. If `recebe_dado` and `final` occur in the same cycle, setting wins and `tem_dado` stays 1.
- A new frame overwrites an unacknowledged character. There is no overrun flag.
- `recebe_dado` has no effect on the FSM.

## Timing
- Reset values: `dados_ascii` = 0, `tem_dado` = 0, `pronto` = 0, `erro_paridade` = 0, `erro_framing` = 0, `db_estado` = 0 (`inicial`).
- Input latency is 2 cycles from `entrada_serial` to `s`.
- Let t0 be the first cycle with `s` = 0 in `inicial`. With H = floor(`CLKS_PER_BIT`/2) and N = `CLKS_PER_BIT`, the samples are:
  - start bit at t0+H;
  - data bit i (i = 0..6) at t0+H+(i+1)·N;
  - parity at t0+H+8N;
  - stop at t0+H+9N.
- `pronto` is high, and the new outputs are visible, in cycle t0+H+9N+1.
- The FSM is back in `inicial` at t0+H+9N+2 and accepts a new start edge from that cycle on. Back-to-back frames with a 1-bit stop time are supported.
- Reset mid-frame returns the FSM to `inicial` and clears all outputs and the shift register. After reset is released, the line must be high before a start bit is detected.

## Configuration
- `RX_FRAMING_CHECK_EN` defined:
  - a stop bit sampled as 0 sets `erro_framing` = 1;
  - `tem_dado` is not set and `dados_ascii` keeps its old value;
  - `pronto` still pulses;
  - the FSM returns to `inicial` only after `s` = 1, so it waits out a break condition.
- `RX_FRAMING_CHECK_EN` not defined: the stop bit is ignored, `erro_framing` is tied to 0, and every frame is delivered.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8.
- Frame "A" (0x41, parity bit 1, stop 1) -> `pronto` pulses at t0+4+72+1, `dados_ascii` = 0x41, `erro_paridade` = 0, `tem_dado` = 1.
- Frame 0x41 with parity bit 0 -> `dados_ascii` = 0x41, `erro_paridade` = 1, `tem_dado` = 1.
- 2-cycle low glitch on an idle line -> FSM returns from `start` to `inicial`, no `pronto`, outputs unchanged.
- "1" (0x31, parity 0) then, back-to-back, "#" (0x23, parity 0) -> two `pronto` pulses 80 cycles apart, final `dados_ascii` = 0x23. A `recebe_dado` pulse afterwards gives `tem_dado` = 0.
- `reset` = 0 during `dados` -> `db_estado` = 0, all outputs 0. After release, a full 0x41 frame is received correctly.
- With `RX_FRAMING_CHECK_EN`, frame 0x41 with stop bit 0 -> `erro_framing` = 1, `tem_dado` stays 0, FSM holds until the line returns high.

Source files
------------

// File: rtl/rx_serial_7o1_if.sv
// Host-side signal bundle for the 7O1 serial receiver: serial line, acknowledge,
// received character, status flags and debug state code.
interface rx_serial_7o1_if;
    logic       entrada_serial;
    logic       recebe_dado;
    logic [6:0] dados_ascii;
    logic       tem_dado;
    logic       pronto;
    logic       erro_paridade;
    logic       erro_framing;
    logic [3:0] db_estado;

    modport master (
        output entrada_serial, recebe_dado,
        input  dados_ascii, tem_dado, pronto, erro_paridade, erro_framing, db_estado
    );

    modport slave (
        input  entrada_serial, recebe_dado,
        output dados_ascii, tem_dado, pronto, erro_paridade, erro_framing, db_estado
    );
endinterface

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver (start, 7 data LSB first, odd parity, stop).
// Optional stop-bit checking is enabled with the RX_FRAMING_CHECK_EN macro.
module rx_serial_7o1 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic           clock,
    input  logic           reset,
    rx_serial_7o1_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        PARADA   = 4'd4,
        FINAL    = 4'd5
    } state_t;

    function automatic logic parity_error(input logic [6:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

    state_t           state, next;
    logic             sync_p0, sync_p1, s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [6:0]       shift_reg;
    logic             par_bit;
    logic             expire, deliver;
    logic             load_half, load_full, shift_en, par_en, stop_en;
    logic [6:0]       dados_ascii;
    logic             tem_dado, pronto, erro_paridade, erro_framing;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= bus.entrada_serial;
            sync_p1 <= sync_p0;
        end
    end
    // synchronised line
    assign s      = sync_p1;
    assign expire = (cnt == CNT_W'(1));

`ifdef RX_FRAMING_CHECK_EN
    assign deliver = s;
`else
    assign deliver = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        case (state)
            INICIAL: if (!s) begin
                load_half = 1'b1;
                next      = START;
            end
            START: if (expire) begin
                if (s) begin
                    next = INICIAL;
                end else begin
                    load_full = 1'b1;
                    next      = DADOS;
                end
            end
            DADOS: if (expire) begin
                shift_en  = 1'b1;
                load_full = 1'b1;
                if (bit_idx == 3'd6) next = PARIDADE;
            end
            PARIDADE: if (expire) begin
                par_en    = 1'b1;
                load_full = 1'b1;
                next      = PARADA;
            end
            PARADA: if (expire) begin
                stop_en = 1'b1;
                next    = FINAL;
            end
`ifdef RX_FRAMING_CHECK_EN
            // hold here through a break condition
            FINAL: if (s) next = INICIAL;
`else
            FINAL: next = INICIAL;
`endif
            default: next = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            if (load_half)     cnt <= HALF;
            else if (load_full) cnt <= FULL;
            else if (cnt != '0) cnt <= cnt - 1'b1;

            if (load_half)     bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;

            if (shift_en) shift_reg <= {s, shift_reg[6:1]};
            if (par_en)   par_bit   <= s;
        end
    end

    // Outputs are registered on the stop-sample edge so they appear with pronto in FINAL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dados_ascii   <= '0;
            tem_dado      <= 1'b0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_framing  <= 1'b0;
        end else begin
            pronto <= stop_en;
            if (stop_en) begin
                erro_paridade <= parity_error(shift_reg, par_bit);
`ifdef RX_FRAMING_CHECK_EN
                erro_framing  <= ~s;
`else
                erro_framing  <= 1'b0;
`endif
                if (deliver) dados_ascii <= shift_reg;
            end
            // an acknowledge in the delivery cycle loses to the set
            if (stop_en && deliver)
                tem_dado <= 1'b1;
            else if (bus.recebe_dado && !(pronto && !erro_framing))
                tem_dado <= 1'b0;
        end
    end

    assign bus.dados_ascii   = dados_ascii;
    assign bus.tem_dado      = tem_dado;
    assign bus.pronto        = pronto;
    assign bus.erro_paridade = erro_paridade;
    assign bus.erro_framing  = erro_framing;
    assign bus.db_estado     = state;
endmodule
